// File: rtl/dlx_pipe_pkg.sv
// Shared DLX pipeline definitions: hazard-controller state encoding,
// special register indices and the source/destination match helper.
package dlx_pipe_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MUL_WAIT = 1'b1
    } state_t;

    localparam logic [0:4] REG_ZERO = 5'd0;
    localparam logic [0:4] REG_LINK = 5'd31;

    // r0 is hardwired to zero, so a write to it can never feed a later read.
    function automatic logic src_hit(input logic uses, input logic [0:4] rs,
                                     input logic [0:4] rd);
        return uses && (rs == rd) && (rd != REG_ZERO);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// ID/EX hazard observation bus plus the stall/flush controls returned to the
// pipeline registers, PC and the EX multiplier.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [0:4]       id_rs1;
    logic [0:4]       id_rs2;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic [0:4]       ex_destReg;
    logic             ex_RegWrite;
    logic             ex_MemToReg;
    logic             ex_mul;
    logic             ex_take_branch;
    logic             perf_clear;
    logic             pc_we;
    logic             ifid_we;
    logic             ifid_flush;
    logic             idex_we;
    logic             idex_bubble;
    logic             exmem_bubble;
    logic             mul_start;
    logic             mul_busy;
    logic             mul_done;
    logic [0:CNT_W-1] stall_cycles;

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_destReg, ex_RegWrite,
               ex_MemToReg, ex_mul, ex_take_branch, perf_clear,
        input  pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_bubble,
               mul_start, mul_busy, mul_done, stall_cycles
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_destReg, ex_RegWrite,
               ex_MemToReg, ex_mul, ex_take_branch, perf_clear,
        output pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_bubble,
               mul_start, mul_busy, mul_done, stall_cycles
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes priority over
// increment and the count sticks at all-ones.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [0:CNT_W-1] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer beside the DLX ID stage: load-use interlock, taken
// branch squash, multi-cycle multiplier freeze and a stalled-cycle counter.
module pipeline_hazard_ctrl
    import dlx_pipe_pkg::*;
#(
    parameter int MUL_CYCLES = 6,
    parameter int CNT_W      = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    pipeline_hazard_ctrl_if.slave  hz
);

    localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          load_use;
    logic          pc_we, ifid_we, ifid_flush, idex_we;
    logic          idex_bubble, exmem_bubble, mul_start, mul_busy, mul_done;

    assign load_use = hz.ex_MemToReg && hz.ex_RegWrite &&
                      (src_hit(hz.id_uses_rs1, hz.id_rs1, hz.ex_destReg) ||
                       src_hit(hz.id_uses_rs2, hz.id_rs2, hz.ex_destReg));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        pc_we        = 1'b1;
        ifid_we      = 1'b1;
        idex_we      = 1'b1;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        exmem_bubble = 1'b0;
        mul_start    = 1'b0;
        mul_busy     = 1'b0;
        mul_done     = 1'b0;
        case (state)
            RUN: begin
                if (hz.ex_take_branch) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end else if (hz.ex_mul) begin
                    mul_start    = 1'b1;
                    pc_we        = 1'b0;
                    ifid_we      = 1'b0;
                    idex_we      = 1'b0;
                    exmem_bubble = 1'b1;
                    cnt_nx       = CW'(MUL_CYCLES - 1);
                    state_nx     = MUL_WAIT;
                end else if (load_use) begin
                    // The load moves on to MEM, so one bubble resolves it.
                    pc_we       = 1'b0;
                    ifid_we     = 1'b0;
                    idex_bubble = 1'b1;
                end
            end
            MUL_WAIT: begin
                mul_busy = 1'b1;
                if (cnt != '0) begin
                    pc_we        = 1'b0;
                    ifid_we      = 1'b0;
                    idex_we      = 1'b0;
                    exmem_bubble = 1'b1;
                    cnt_nx       = cnt - CW'(1);
                end else begin
                    mul_done = 1'b1;
                    state_nx = RUN;
                end
            end
            default: state_nx = RUN;
        endcase
        // Reset releases the front end in the same cycle, even mid-multiply.
        if (!reset) begin
            pc_we        = 1'b1;
            ifid_we      = 1'b1;
            idex_we      = 1'b1;
            ifid_flush   = 1'b0;
            idex_bubble  = 1'b0;
            exmem_bubble = 1'b0;
            mul_start    = 1'b0;
            mul_busy     = 1'b0;
            mul_done     = 1'b0;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (!pc_we),
        .clr   (hz.perf_clear),
        .count (hz.stall_cycles)
    );

    assign hz.pc_we        = pc_we;
    assign hz.ifid_we      = ifid_we;
    assign hz.ifid_flush   = ifid_flush;
    assign hz.idex_we      = idex_we;
    assign hz.idex_bubble  = idex_bubble;
    assign hz.exmem_bubble = exmem_bubble;
    assign hz.mul_start    = mul_start;
    assign hz.mul_busy     = mul_busy;
    assign hz.mul_done     = mul_done;

endmodule
